noc_traffic_node: RTL

//  Parametrised NoC endpoint traffic generator/checker for router-mesh benches. Sends one packet per

---
 rtl/noc_traffic_node.sv | 293 +++++++++++++++++++++++++++++
 1 files changed

// File: rtl/noc_traffic_node.sv
`default_nettype none
// ============================================================================
// Module   : noc_traffic_node
// Brief    : NoC endpoint that sends HEAD/DATA/TAIL packets on a chosen VC and
//            checks incoming packets independently per VC.
// Revision : 1.0
// ============================================================================
module noc_traffic_node #(
    parameter int X_ID    = 0,
    parameter int Y_ID    = 0,
    parameter int ID_X_W  = 2,
    parameter int ID_Y_W  = 2,
    parameter int DATA_W  = 64,
    parameter int VC_NUM  = 2,
    parameter int MAX_LEN = 8,
    parameter int VC_W    = (VC_NUM > 1) ? $clog2(VC_NUM) : 1
) (
    input  logic                       noc_clk,
    input  logic                       noc_rst,
    input  logic                       send_start,
    input  logic [ID_X_W-1:0]          cfg_dst_x,
    input  logic [ID_Y_W-1:0]          cfg_dst_y,
    input  logic [7:0]                 cfg_len,
    input  logic [VC_W-1:0]            cfg_vc,
    output logic                       tx_busy,
    output logic [VC_NUM-1:0]          out_valid,
    input  logic [VC_NUM-1:0]          out_ready,
    output logic [DATA_W-1:0]          out_flit,
    input  logic [VC_NUM-1:0]          in_valid,
    output logic [VC_NUM-1:0]          in_ready,
    input  logic [DATA_W-1:0]          in_flit,
    input  logic                       rx_stall,
    output logic                       rx_done,
    output logic [ID_X_W+ID_Y_W-1:0]   rx_src,
    output logic                       err_pulse,
    output logic [15:0]                tx_cnt,
    output logic [15:0]                rx_cnt,
    output logic [15:0]                err_cnt
);

    localparam int HDR_W  = 4 + 2 * (ID_X_W + ID_Y_W) + 16;
    localparam int HDR_SH = DATA_W - HDR_W;
    localparam int DAT_SH = DATA_W - 20;

    localparam logic [3:0]        c_TYP_HEAD = 4'hA;
    localparam logic [3:0]        c_TYP_DATA = 4'h3;
    localparam logic [3:0]        c_TYP_TAIL = 4'h5;
    localparam logic [ID_X_W-1:0] c_MY_X     = ID_X_W'(X_ID);
    localparam logic [ID_Y_W-1:0] c_MY_Y     = ID_Y_W'(Y_ID);
    localparam logic [7:0]        c_MAX_LEN  = 8'(MAX_LEN);

    localparam logic [1:0] c_TX_IDLE = 2'd0;
    localparam logic [1:0] c_TX_HEAD = 2'd1;
    localparam logic [1:0] c_TX_DATA = 2'd2;
    localparam logic [1:0] c_TX_TAIL = 2'd3;

    localparam logic [0:0] c_RX_IDLE = 1'b0;
    localparam logic [0:0] c_RX_DATA = 1'b1;

    // Flits are packed from the MSB down; unused low bits stay zero.
    function automatic logic [DATA_W-1:0] f_ht(input logic [3:0] typ,
                                               input logic [ID_X_W-1:0] dx,
                                               input logic [ID_Y_W-1:0] dy,
                                               input logic [7:0] len,
                                               input logic [7:0] seq);
        logic [HDR_W-1:0] f;
        f = {typ, c_MY_X, c_MY_Y, dx, dy, len, seq};
        return DATA_W'(f) << HDR_SH;
    endfunction

    function automatic logic [DATA_W-1:0] f_data(input logic [7:0] seq,
                                                 input logic [7:0] idx);
        logic [19:0] f;
        f = {c_TYP_DATA, seq, idx};
        return DATA_W'(f) << DAT_SH;
    endfunction

    logic [1:0]          tx_state_q, tx_state_d;
    logic [ID_X_W-1:0]   tx_dx_q, tx_dx_d;
    logic [ID_Y_W-1:0]   tx_dy_q, tx_dy_d;
    logic [7:0]          tx_len_q, tx_len_d;
    logic [7:0]          tx_idx_q, tx_idx_d;
    logic [7:0]          tx_seq_q, tx_seq_d;
    logic [VC_NUM-1:0]   out_valid_q, out_valid_d;
    logic [DATA_W-1:0]   out_flit_q, out_flit_d;
    logic [15:0]         tx_cnt_q, tx_cnt_d;
    logic                w_tx_fire;

    assign w_tx_fire = |(out_valid_q & out_ready);

    always_comb begin
        tx_state_d  = tx_state_q;
        tx_dx_d     = tx_dx_q;
        tx_dy_d     = tx_dy_q;
        tx_len_d    = tx_len_q;
        tx_idx_d    = tx_idx_q;
        tx_seq_d    = tx_seq_q;
        out_valid_d = out_valid_q;
        out_flit_d  = out_flit_q;
        tx_cnt_d    = tx_cnt_q;
        case (tx_state_q)
            c_TX_IDLE: begin
                if (send_start && (cfg_len <= c_MAX_LEN) && (32'(cfg_vc) < VC_NUM)) begin
                    tx_dx_d     = cfg_dst_x;
                    tx_dy_d     = cfg_dst_y;
                    tx_len_d    = cfg_len;
                    tx_idx_d    = 8'd0;
                    out_valid_d = VC_NUM'(1) << cfg_vc;
                    out_flit_d  = f_ht(c_TYP_HEAD, cfg_dst_x, cfg_dst_y, cfg_len, tx_seq_q);
                    tx_state_d  = c_TX_HEAD;
                end
            end
            c_TX_HEAD: begin
                if (w_tx_fire) begin
                    if (tx_len_q == 8'd0) begin
                        out_flit_d = f_ht(c_TYP_TAIL, tx_dx_q, tx_dy_q, tx_len_q, tx_seq_q);
                        tx_state_d = c_TX_TAIL;
                    end else begin
                        out_flit_d = f_data(tx_seq_q, 8'd0);
                        tx_state_d = c_TX_DATA;
                    end
                end
            end
            c_TX_DATA: begin
                if (w_tx_fire) begin
                    if (tx_idx_q == tx_len_q - 8'd1) begin
                        out_flit_d = f_ht(c_TYP_TAIL, tx_dx_q, tx_dy_q, tx_len_q, tx_seq_q);
                        tx_state_d = c_TX_TAIL;
                    end else begin
                        tx_idx_d   = tx_idx_q + 8'd1;
                        out_flit_d = f_data(tx_seq_q, tx_idx_q + 8'd1);
                    end
                end
            end
            c_TX_TAIL: begin
                if (w_tx_fire) begin
                    out_valid_d = '0;
                    out_flit_d  = '0;
                    tx_seq_d    = tx_seq_q + 8'd1;
                    tx_cnt_d    = (tx_cnt_q != 16'hFFFF) ? tx_cnt_q + 16'd1 : tx_cnt_q;
                    tx_state_d  = c_TX_IDLE;
                end
            end
            default: tx_state_d = c_TX_IDLE;
        endcase
    end

    always_ff @(posedge noc_clk) begin
        if (noc_rst) begin
            tx_state_q  <= c_TX_IDLE;
            tx_dx_q     <= '0;
            tx_dy_q     <= '0;
            tx_len_q    <= '0;
            tx_idx_q    <= '0;
            tx_seq_q    <= '0;
            out_valid_q <= '0;
            out_flit_q  <= '0;
            tx_cnt_q    <= '0;
        end else begin
            tx_state_q  <= tx_state_d;
            tx_dx_q     <= tx_dx_d;
            tx_dy_q     <= tx_dy_d;
            tx_len_q    <= tx_len_d;
            tx_idx_q    <= tx_idx_d;
            tx_seq_q    <= tx_seq_d;
            out_valid_q <= out_valid_d;
            out_flit_q  <= out_flit_d;
            tx_cnt_q    <= tx_cnt_d;
        end
    end

    assign tx_busy   = (tx_state_q != c_TX_IDLE);
    assign out_valid = out_valid_q;
    assign out_flit  = out_flit_q;
    assign tx_cnt    = tx_cnt_q;

    logic [3:0]          w_typ;
    logic [ID_X_W-1:0]   w_sx, w_dx;
    logic [ID_Y_W-1:0]   w_sy, w_dy;
    logic [7:0]          w_len, w_seq, w_dseq, w_didx;
    logic                w_dst_me;
    logic [VC_NUM-1:0]   w_rx_acc;
    logic                w_rx_multi;
    logic                w_unused;

    assign {w_typ, w_sx, w_sy, w_dx, w_dy, w_len, w_seq} = in_flit[DATA_W-1 -: HDR_W];
    assign {w_dseq, w_didx} = in_flit[DATA_W-5 -: 16];
    assign w_dst_me   = (w_dx == c_MY_X) && (w_dy == c_MY_Y);
    assign in_ready   = {VC_NUM{~noc_rst & ~rx_stall}};
    assign w_rx_acc   = in_valid & in_ready;
    assign w_rx_multi = (w_rx_acc & (w_rx_acc - VC_NUM'(1))) != '0;
    assign w_unused   = ^in_flit;

    logic [0:0]          rx_state_q [VC_NUM], rx_state_d [VC_NUM];
    logic [ID_X_W-1:0]   rx_sx_q    [VC_NUM], rx_sx_d    [VC_NUM];
    logic [ID_Y_W-1:0]   rx_sy_q    [VC_NUM], rx_sy_d    [VC_NUM];
    logic [7:0]          rx_len_q   [VC_NUM], rx_len_d   [VC_NUM];
    logic [7:0]          rx_seq_q   [VC_NUM], rx_seq_d   [VC_NUM];
    logic [7:0]          rx_idx_q   [VC_NUM], rx_idx_d   [VC_NUM];
    logic                rx_done_q, rx_done_d;
    logic                err_q, err_d;
    logic [ID_X_W+ID_Y_W-1:0] rx_src_q, rx_src_d;
    logic [15:0]         rx_cnt_q, rx_cnt_d;
    logic [15:0]         err_cnt_q, err_cnt_d;

    always_comb begin
        rx_state_d = rx_state_q;
        rx_sx_d    = rx_sx_q;
        rx_sy_d    = rx_sy_q;
        rx_len_d   = rx_len_q;
        rx_seq_d   = rx_seq_q;
        rx_idx_d   = rx_idx_q;
        rx_done_d  = 1'b0;
        err_d      = 1'b0;
        rx_src_d   = rx_src_q;
        if (w_rx_multi) begin
            err_d = 1'b1;
        end else begin
            for (int v = 0; v < VC_NUM; v++) begin
                if (w_rx_acc[v]) begin
                    // A HEAD always (re)starts the VC when addressed to us.
                    if (w_typ == c_TYP_HEAD) begin
                        if ((rx_state_q[v] == c_RX_DATA) || !w_dst_me) err_d = 1'b1;
                        if (w_dst_me) begin
                            rx_state_d[v] = c_RX_DATA;
                            rx_sx_d[v]    = w_sx;
                            rx_sy_d[v]    = w_sy;
                            rx_len_d[v]   = w_len;
                            rx_seq_d[v]   = w_seq;
                            rx_idx_d[v]   = 8'd0;
                        end else begin
                            rx_state_d[v] = c_RX_IDLE;
                        end
                    end else if (rx_state_q[v] == c_RX_IDLE) begin
                        err_d = 1'b1;
                    end else if ((w_typ == c_TYP_DATA) && (w_dseq == rx_seq_q[v]) &&
                                 (w_didx == rx_idx_q[v]) && (rx_idx_q[v] < rx_len_q[v])) begin
                        rx_idx_d[v] = rx_idx_q[v] + 8'd1;
                    end else if ((w_typ == c_TYP_TAIL) && (w_sx == rx_sx_q[v]) &&
                                 (w_sy == rx_sy_q[v]) && w_dst_me && (w_len == rx_len_q[v]) &&
                                 (w_seq == rx_seq_q[v]) && (rx_idx_q[v] == rx_len_q[v])) begin
                        rx_done_d     = 1'b1;
                        rx_src_d      = {rx_sx_q[v], rx_sy_q[v]};
                        rx_state_d[v] = c_RX_IDLE;
                    end else begin
                        err_d         = 1'b1;
                        rx_state_d[v] = c_RX_IDLE;
                    end
                end
            end
        end
        rx_cnt_d  = (rx_done_d && rx_cnt_q != 16'hFFFF) ? rx_cnt_q + 16'd1 : rx_cnt_q;
        err_cnt_d = (err_d && err_cnt_q != 16'hFFFF) ? err_cnt_q + 16'd1 : err_cnt_q;
    end

    always_ff @(posedge noc_clk) begin
        if (noc_rst) begin
            for (int v = 0; v < VC_NUM; v++) begin
                rx_state_q[v] <= c_RX_IDLE;
                rx_sx_q[v]    <= '0;
                rx_sy_q[v]    <= '0;
                rx_len_q[v]   <= '0;
                rx_seq_q[v]   <= '0;
                rx_idx_q[v]   <= '0;
            end
            rx_done_q <= 1'b0;
            err_q     <= 1'b0;
            rx_src_q  <= '0;
            rx_cnt_q  <= '0;
            err_cnt_q <= '0;
        end else begin
            rx_state_q <= rx_state_d;
            rx_sx_q    <= rx_sx_d;
            rx_sy_q    <= rx_sy_d;
            rx_len_q   <= rx_len_d;
            rx_seq_q   <= rx_seq_d;
            rx_idx_q   <= rx_idx_d;
            rx_done_q  <= rx_done_d;
            err_q      <= err_d;
            rx_src_q   <= rx_src_d;
            rx_cnt_q   <= rx_cnt_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

    assign rx_done   = rx_done_q;
    assign err_pulse = err_q;
    assign rx_src    = rx_src_q;
    assign rx_cnt    = rx_cnt_q;
    assign err_cnt   = err_cnt_q;

endmodule
`default_nettype wire
